// File: rtl/conv_mmio_bank_if.sv
// Write/read port between the AXI slave front end and the MMIO register bank.
// The master drives the strobes; the bank returns registered read data and the read-accept gate.
interface conv_mmio_bank_if #(
    parameter int ADDR_BW = 32,
    parameter int DATA_BW = 32,
    parameter int STRB_BW = DATA_BW / 8
);
    logic               w_en;
    logic [ADDR_BW-1:0] w_addr;
    logic [DATA_BW-1:0] w_data;
    logic [STRB_BW-1:0] w_strb;
    logic               r_en;
    logic [ADDR_BW-1:0] r_addr;
    logic [DATA_BW-1:0] r_data;
    logic               done;

    modport master (
        output w_en, w_addr, w_data, w_strb, r_en, r_addr,
        input  r_data, done
    );

    modport slave (
        input  w_en, w_addr, w_data, w_strb, r_en, r_addr,
        output r_data, done
    );
endinterface

// File: rtl/conv_mmio_bank.sv
// Control/status registers and a DEPTH-word data buffer. A sequential engine sums LEN buffer
// words on START. done is low while the engine is busy.
module conv_mmio_bank #(
    parameter int                ADDR_BW  = 32,
    parameter int                DATA_BW  = 32,
    parameter int                STRB_BW  = DATA_BW / 8,
    parameter int                DEPTH    = 256,
    parameter logic [ADDR_BW-1:0] BUF_BASE = 'h1000
) (
    input  logic ACLK,
    input  logic ARESETn,
    conv_mmio_bank_if.slave bus
);
    localparam int IDX_BW  = $clog2(DEPTH);
    localparam int LEN_BW  = IDX_BW + 1;
    localparam int WORD_BW = ADDR_BW - 2;

    localparam logic [WORD_BW-1:0] A_CTRL   = WORD_BW'(0);
    localparam logic [WORD_BW-1:0] A_STATUS = WORD_BW'(1);
    localparam logic [WORD_BW-1:0] A_LEN    = WORD_BW'(2);
    localparam logic [WORD_BW-1:0] A_CYCLES = WORD_BW'(3);
    localparam logic [WORD_BW-1:0] A_RESULT = WORD_BW'(4);

    localparam logic [ADDR_BW-1:0] BUF_BYTES = ADDR_BW'(4 * DEPTH);
    localparam logic [LEN_BW-1:0]  LEN_DEPTH = LEN_BW'(DEPTH);
    localparam logic [LEN_BW-1:0]  LEN_ONE   = LEN_BW'(1);
    localparam logic [IDX_BW-1:0]  IDX_ONE   = IDX_BW'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t             state_reg, state_next;
    logic [LEN_BW-1:0]  len_reg, n_reg, idx_reg;
    logic [DATA_BW-1:0] acc_reg, cycles_reg, result_reg;
    logic               done_reg, werr_reg;
    logic               sel_buf_reg;
    logic [DATA_BW-1:0] reg_rd_reg, buf_rd_reg, eng_q_reg;

    logic [DATA_BW-1:0] mem [DEPTH];

    // Address decode
    logic [ADDR_BW-1:0] w_off, r_off;
    logic [WORD_BW-1:0] w_word, r_word;
    logic               w_buf_hit, r_buf_hit;
    logic [IDX_BW-1:0]  w_buf_idx, r_buf_idx, eng_addr;

    assign w_off     = bus.w_addr - BUF_BASE;
    assign r_off     = bus.r_addr - BUF_BASE;
    assign w_buf_hit = (w_off < BUF_BYTES);
    assign r_buf_hit = (r_off < BUF_BYTES);
    assign w_buf_idx = w_off[IDX_BW+1:2];
    assign r_buf_idx = r_off[IDX_BW+1:2];
    assign w_word    = bus.w_addr[ADDR_BW-1:2];
    assign r_word    = bus.r_addr[ADDR_BW-1:2];

    logic busy, ctrl_wr, start_req, clr_req, len_wr, mem_we, start_run;
    logic [LEN_BW-1:0] len_eff;

    assign busy      = (state_reg != S_IDLE);
    assign ctrl_wr   = bus.w_en && !w_buf_hit && (w_word == A_CTRL) && bus.w_strb[0];
    assign start_req = ctrl_wr && bus.w_data[0];
    assign clr_req   = ctrl_wr && bus.w_data[1];
    assign len_wr    = bus.w_en && !w_buf_hit && (w_word == A_LEN) && bus.w_strb[0];
    assign mem_we    = bus.w_en && w_buf_hit && !busy;
    assign len_eff   = (len_reg > LEN_DEPTH) ? LEN_DEPTH : len_reg;

    // Engine prefetches one word ahead so the registered RAM read lines up with each RUN edge
    assign eng_addr  = (state_reg == S_RUN) ? (idx_reg[IDX_BW-1:0] + IDX_ONE) : '0;

    always_comb begin
        state_next = state_reg;
        start_run  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start_req) begin
                    start_run  = 1'b1;
                    state_next = (len_eff == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN:    if (idx_reg == n_reg - LEN_ONE) state_next = S_FINISH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_reg  <= S_IDLE;
            len_reg    <= '0;
            n_reg      <= '0;
            idx_reg    <= '0;
            acc_reg    <= '0;
            cycles_reg <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
            werr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (clr_req) begin
                done_reg <= 1'b0;
                werr_reg <= 1'b0;
            end
            if (bus.w_en && w_buf_hit && busy) werr_reg <= 1'b1;
            if (len_wr) len_reg <= bus.w_data[LEN_BW-1:0];
            // Later assignments to done_reg override the clear above
            case (state_reg)
                S_IDLE: begin
                    if (start_run) begin
                        idx_reg    <= '0;
                        acc_reg    <= '0;
                        cycles_reg <= '0;
                        done_reg   <= 1'b0;
                        n_reg      <= len_eff;
                    end
                end
                S_RUN: begin
                    acc_reg    <= acc_reg + eng_q_reg;
                    idx_reg    <= idx_reg + LEN_ONE;
                    cycles_reg <= cycles_reg + DATA_BW'(1);
                end
                S_FINISH: begin
                    result_reg <= acc_reg;
                    done_reg   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Buffer RAM: byte-lane write, registered reads for the bus and the engine
    always_ff @(posedge ACLK) begin
        for (int b = 0; b < STRB_BW; b++) begin
            if (mem_we && bus.w_strb[b]) mem[w_buf_idx][b*8 +: 8] <= bus.w_data[b*8 +: 8];
        end
        if (bus.r_en && r_buf_hit && !busy) buf_rd_reg <= mem[r_buf_idx];
        eng_q_reg <= mem[eng_addr];
    end

    logic [DATA_BW-1:0] rd_val;
    always_comb begin
        rd_val = '0;
        if (!r_buf_hit) begin
            case (r_word)
                A_STATUS: rd_val = {{(DATA_BW-3){1'b0}}, werr_reg, done_reg, busy};
                A_LEN:    rd_val = {{(DATA_BW-LEN_BW){1'b0}}, len_reg};
                A_CYCLES: rd_val = cycles_reg;
                A_RESULT: rd_val = result_reg;
                default:  rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            sel_buf_reg <= 1'b0;
            reg_rd_reg  <= '0;
        end else if (bus.r_en) begin
            sel_buf_reg <= r_buf_hit && !busy;
            reg_rd_reg  <= rd_val;
        end
    end

    assign bus.r_data = sel_buf_reg ? buf_rd_reg : reg_rd_reg;
    assign bus.done   = !busy;
endmodule

// File: tb/tb_conv_mmio_bank.sv
// Bench for conv_mmio_bank: vector table for decode/byte lanes, hand sequences for engine corners.
module tb_conv_mmio_bank;
    localparam logic [31:0] BUF    = 32'h1000;
    localparam logic [31:0] CTRL   = 32'h00;
    localparam logic [31:0] STATUS = 32'h04;
    localparam logic [31:0] LEN    = 32'h08;
    localparam logic [31:0] CYC    = 32'h0C;
    localparam logic [31:0] RES    = 32'h10;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    conv_mmio_bank_if #(.ADDR_BW(32), .DATA_BW(32)) bus ();

    conv_mmio_bank #(.ADDR_BW(32), .DATA_BW(32), .DEPTH(256), .BUF_BASE(32'h1000)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        string       name;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge ACLK);
        bus.w_en = 1'b1; bus.w_addr = a; bus.w_data = d; bus.w_strb = s;
        @(posedge ACLK); #1;
        bus.w_en = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] e, input string nm);
        sb_t x;
        @(negedge ACLK);
        bus.r_en = 1'b1; bus.r_addr = a;
        sb.push_back('{nm, e});
        @(posedge ACLK); #1;
        bus.r_en = 1'b0;
        x = sb.pop_front();
        check(x.name, bus.r_data, x.exp);
    endtask

    // Counts sampled cycles with done low, starting right after the START edge
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (bus.done !== 1'b1 && cnt < 1000) begin
            cnt++;
            @(posedge ACLK); #1;
        end
    endtask

    initial begin
        int cnt;
        bus.w_en = 0; bus.w_addr = 0; bus.w_data = 0; bus.w_strb = 0;
        bus.r_en = 0; bus.r_addr = 0;

        // Reset
        repeat (2) @(posedge ACLK);
        #1;
        check("reset_done", {31'b0, bus.done}, 32'h1);
        check("reset_rdata", bus.r_data, 32'h0);
        @(negedge ACLK); ARESETn = 1'b1;
        do_read(STATUS, 32'h0, "reset_status");
        do_read(LEN,    32'h0, "reset_len");
        do_read(CYC,    32'h0, "reset_cycles");
        do_read(RES,    32'h0, "reset_result");

        // Decode and byte-lane table
        vecs.push_back('{1'b1, BUF + 8,        32'h0,        4'hF, 32'h0,        "w_buf8_zero"});
        vecs.push_back('{1'b1, BUF + 8,        32'h11223344, 4'h5, 32'h0,        "w_buf8_strb"});
        vecs.push_back('{1'b0, BUF + 8,        32'h0,        4'h0, 32'h00220044, "r_buf8_strb"});
        vecs.push_back('{1'b0, BUF + 9,        32'h0,        4'h0, 32'h00220044, "r_buf9_lowbits"});
        vecs.push_back('{1'b1, LEN,            32'h12345678, 4'h1, 32'h0,        "w_len"});
        vecs.push_back('{1'b0, LEN,            32'h0,        4'h0, 32'h00000078, "r_len_mask"});
        vecs.push_back('{1'b1, LEN,            32'h00000011, 4'h2, 32'h0,        "w_len_nostrb0"});
        vecs.push_back('{1'b0, LEN,            32'h0,        4'h0, 32'h00000078, "r_len_kept"});
        vecs.push_back('{1'b0, CTRL,           32'h0,        4'h0, 32'h0,        "r_ctrl_zero"});
        vecs.push_back('{1'b1, 32'h20,         32'hCAFEF00D, 4'hF, 32'h0,        "w_unmapped"});
        vecs.push_back('{1'b0, 32'h20,         32'h0,        4'h0, 32'h0,        "r_unmapped"});
        vecs.push_back('{1'b1, BUF + 4*255,    32'hDEADBEEF, 4'hF, 32'h0,        "w_buf_last"});
        vecs.push_back('{1'b0, BUF + 4*255,    32'h0,        4'h0, 32'hDEADBEEF, "r_buf_last"});
        vecs.push_back('{1'b0, BUF + 4*256,    32'h0,        4'h0, 32'h0,        "r_above_buf"});
        vecs.push_back('{1'b0, BUF - 4,        32'h0,        4'h0, 32'h0,        "r_below_buf"});
        vecs.push_back('{1'b0, BUF + 8,        32'h0,        4'h0, 32'h00220044, "r_buf8_again"});
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            else            do_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end
        repeat (2) @(posedge ACLK);
        #1;
        check("rdata_held", bus.r_data, 32'h00220044);

        // Basic run: 1+2+3+4
        for (int i = 0; i < 4; i++) do_write(BUF + 4*i, i + 1, 4'hF);
        do_write(LEN, 32'd4, 4'hF);
        do_write(CTRL, 32'h1, 4'h1);
        wait_idle(cnt);
        check("run4_busy_cycles", cnt, 32'd5);
        do_read(RES,    32'd10, "run4_result");
        do_read(CYC,    32'd4,  "run4_cycles");
        do_read(STATUS, 32'h2,  "run4_status");

        // LEN=0
        do_write(LEN, 32'd0, 4'hF);
        do_write(CTRL, 32'h1, 4'h1);
        wait_idle(cnt);
        check("len0_busy_cycles", cnt, 32'd1);
        do_read(RES, 32'd0, "len0_result");

        // LEN beyond DEPTH clamps
        do_write(LEN, 32'd261, 4'hF);
        do_write(CTRL, 32'h1, 4'h1);
        wait_idle(cnt);
        check("lenbig_busy_cycles", cnt, 32'd257);
        do_read(CYC, 32'd256, "lenbig_cycles");

        // Wrap-around
        do_write(BUF + 0, 32'hFFFFFFFF, 4'hF);
        do_write(BUF + 4, 32'd2, 4'hF);
        do_write(LEN, 32'd2, 4'hF);
        do_write(CTRL, 32'h1, 4'h1);
        wait_idle(cnt);
        do_read(RES, 32'd1, "wrap_result");

        // CLR_DONE on the FINISH edge: DONE wins
        do_write(LEN, 32'd0, 4'hF);
        do_write(CTRL, 32'h1, 4'h1);
        do_write(CTRL, 32'h2, 4'h1);
        do_read(STATUS, 32'h2, "clr_at_finish_status");

        // Busy behaviour; START+CLR_DONE together still starts a run
        for (int i = 0; i < 8; i++) do_write(BUF + 4*i, i + 1, 4'hF);
        do_write(LEN, 32'd8, 4'hF);
        do_write(CTRL, 32'h3, 4'h1);
        do_write(BUF + 0, 32'h99, 4'hF);
        do_write(CTRL, 32'h1, 4'h1);
        do_read(STATUS, 32'h5, "busy_status");
        do_read(BUF + 4, 32'h0, "busy_buf_read");
        do_write(LEN, 32'd3, 4'hF);
        wait_idle(cnt);
        check("busy_done_seen", {31'b0, bus.done}, 32'h1);
        do_read(RES,     32'd36, "busy_result");
        do_read(CYC,     32'd8,  "busy_cycles");
        do_read(LEN,     32'd3,  "busy_len_write");
        do_read(BUF + 0, 32'd1,  "busy_buf_unchanged");
        do_read(STATUS,  32'h6,  "busy_status_after");
        do_write(CTRL, 32'h2, 4'h1);
        do_read(STATUS,  32'h0,  "clr_done_status");

        // Reset mid-run
        do_write(LEN, 32'd8, 4'hF);
        do_write(CTRL, 32'h1, 4'h1);
        @(posedge ACLK);
        @(negedge ACLK); ARESETn = 1'b0;
        @(posedge ACLK); #1;
        check("midreset_done", {31'b0, bus.done}, 32'h1);
        @(negedge ACLK); ARESETn = 1'b1;
        do_read(STATUS, 32'h0, "midreset_status");
        do_read(RES,    32'h0, "midreset_result");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
